// File: rtl/wormhole_rr_arbiter.sv
// Wormhole round-robin arbiter: one output port shared by five inputs, and a packet keeps the output until it completes.
// Optional macro ARB_TIMEOUT_EN adds a stall watchdog that aborts a packet after 255 grant-less LOCK cycles.
module wormhole_rr_arbiter #(
  parameter int LEN_W = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [4:0]         req,
  input  logic [14:0]        flit_id,
  input  logic [5*LEN_W-1:0] length,
  input  logic               out_ready,
  output logic [4:0]         grant,
  output logic               busy,
  output logic [2:0]         owner,
  output logic               timeout
);

  localparam int CNT_W = LEN_W + 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] LOCK = 1'b1;

  localparam logic [2:0] HEAD = 3'b001;
  localparam logic [2:0] TAIL = 3'b100;

  // Handshake: grant[i] is both the FIFO read strobe and the crossbar select. A flit
  // moves only in a cycle where the owner's req and out_ready are both high; grant is
  // that AND, taken in the same cycle from the registered owner/state.
  logic [0:0]       state;
  logic [2:0]       ptr;
  logic [CNT_W-1:0] cnt;

  logic [4:0]       cand;
  logic             win_found;
  logic [2:0]       win_idx;
  logic [LEN_W-1:0] win_len;
  logic [2:0]       owner_flit;
  logic             grant_any;
  logic             release_pkt;

  function automatic logic [2:0] wrap_add(input logic [2:0] a, input logic [2:0] b);
    logic [3:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s >= 4'd5) ? 3'(s - 4'd5) : s[2:0];
  endfunction

  always_comb begin
    for (int i = 0; i < 5; i++) begin
      cand[i] = req[i] && (flit_id[3*i +: 3] == HEAD);
    end
  end

  // Search starts one past the last winner, so the previous owner is examined last.
  always_comb begin
    win_found = 1'b0;
    win_idx   = 3'd0;
    for (int k = 1; k <= 5; k++) begin
      if (!win_found && cand[wrap_add(ptr, 3'(k))]) begin
        win_found = 1'b1;
        win_idx   = wrap_add(ptr, 3'(k));
      end
    end
  end

  always_comb begin
    win_len    = '0;
    owner_flit = 3'd0;
    for (int i = 0; i < 5; i++) begin
      if (win_idx == 3'(i)) win_len = length[LEN_W*i +: LEN_W];
      if (owner == 3'(i)) owner_flit = flit_id[3*i +: 3];
    end
  end

  assign grant_any   = (state == LOCK) && req[owner] && out_ready;
  assign grant       = grant_any ? (5'b00001 << owner) : 5'b00000;
  assign busy        = (state == LOCK);
  assign release_pkt = grant_any && ((cnt == CNT_W'(1)) || (owner_flit == TAIL));

`ifdef ARB_TIMEOUT_EN
  logic [7:0] stall;

  assign timeout = (state == LOCK) && !grant_any && (stall == 8'hFF);

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall <= 8'd0;
    end else if (state == IDLE || grant_any || timeout) begin
      stall <= 8'd0;
    end else begin
      stall <= stall + 8'd1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      owner <= 3'd0;
      ptr   <= 3'd4;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            state <= LOCK;
            owner <= win_idx;
            ptr   <= win_idx;
            cnt   <= {1'b0, win_len} + CNT_W'(1);
          end
        end
        default: begin
          if (grant_any) begin
            cnt <= cnt - CNT_W'(1);
            if (release_pkt) state <= IDLE;
          end
`ifdef ARB_TIMEOUT_EN
          // Watchdog abort: ptr already equals owner, so round-robin resumes after it.
          if (timeout) begin
            state <= IDLE;
            ptr   <= owner;
          end
`endif
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wormhole_rr_arbiter.sv
// Directed bench for wormhole_rr_arbiter: priority rotation, multi-flit packets, stalls,
// early tail, reset mid-packet and the ARB_TIMEOUT_EN watchdog.
module tb_wormhole_rr_arbiter;

  localparam int LEN_W = 12;

  logic               clk;
  logic               rst;
  logic [4:0]         req;
  logic [14:0]        flit_id;
  logic [5*LEN_W-1:0] length;
  logic               out_ready;
  logic [4:0]         grant;
  logic               busy;
  logic [2:0]         owner;
  logic               timeout;

  int vectors     = 0;
  int miscompares = 0;

  logic [4:0] exp_q[$];

  localparam logic [2:0] HEAD = 3'b001;
  localparam logic [2:0] BODY = 3'b010;
  localparam logic [2:0] TAIL = 3'b100;

  wormhole_rr_arbiter #(.LEN_W(LEN_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .flit_id   (flit_id),
    .length    (length),
    .out_ready (out_ready),
    .grant     (grant),
    .busy      (busy),
    .owner     (owner),
    .timeout   (timeout)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic at_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_flit(input int i, input logic [2:0] t);
    flit_id[3*i +: 3] = t;
  endtask

  task automatic set_len(input int i, input int n);
    length[LEN_W*i +: LEN_W] = LEN_W'(n);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int to_cycle;
    int to_count;
    logic busy_after;

    rst = 1'b0; req = 5'b0; flit_id = '0; length = '0; out_ready = 1'b1;
    at_cycle();
    req = 5'b11111;
    for (int i = 0; i < 5; i++) set_flit(i, HEAD);
    at_cycle();
    #1;
    chk("reset_grant", 32'(grant), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_owner", 32'(owner), 32'd0);
    chk("reset_timeout", 32'(timeout), 32'd0);

    // Priority after reset: L,N,E,W,S,L, one idle cycle between grants.
    exp_q = '{5'd0, 5'd1, 5'd0, 5'd2, 5'd0, 5'd4, 5'd0, 5'd8, 5'd0, 5'd16, 5'd0, 5'd1};
    rst = 1'b1;
    for (int n = 0; n < 12; n++) begin
      logic [4:0] e;
      if (n > 0) begin
        at_cycle();
        #1;
      end
      e = exp_q.pop_front();
      chk($sformatf("prio_grant_%0d", n), 32'(grant), 32'(e));
      chk($sformatf("prio_busy_%0d", n), 32'(busy), 32'(e != 5'd0));
    end
    at_cycle();
    req = 5'b0;
    #1;
    chk("prio_release_busy", 32'(busy), 32'd0);

    // Multi-flit: N len 3, W header waiting.
    at_cycle();
    set_len(1, 3); set_len(3, 0);
    req = 5'b01010;
    #1;
    chk("mf_idle_grant", 32'(grant), 32'd0);
    for (int n = 0; n < 4; n++) begin
      at_cycle();
      if (n == 1 || n == 2) set_flit(1, BODY);
      if (n == 3) set_flit(1, TAIL);
      #1;
      chk($sformatf("mf_grant_%0d", n), 32'(grant), 32'h02);
      chk($sformatf("mf_owner_%0d", n), 32'(owner), 32'd1);
    end
    at_cycle();
    req = 5'b01000;
    #1;
    chk("mf_bubble_busy", 32'(busy), 32'd0);
    chk("mf_bubble_grant", 32'(grant), 32'd0);
    at_cycle();
    #1;
    chk("mf_w_grant", 32'(grant), 32'h08);
    chk("mf_w_owner", 32'(owner), 32'd3);
    at_cycle();
    req = 5'b0;
    #1;
    chk("mf_w_release", 32'(busy), 32'd0);

    // Stall: E len 3, out_ready low 10 cycles after 2 grants, L waiting.
    at_cycle();
    set_flit(2, HEAD); set_len(2, 3);
    set_flit(0, HEAD); set_len(0, 0);
    req = 5'b00100;
    #1;
    chk("st_idle_grant", 32'(grant), 32'd0);
    at_cycle();
    #1;
    chk("st_grant_0", 32'(grant), 32'h04);
    at_cycle();
    set_flit(2, BODY);
    #1;
    chk("st_grant_1", 32'(grant), 32'h04);
    for (int n = 0; n < 10; n++) begin
      at_cycle();
      out_ready = 1'b0;
      req = 5'b00101;
      #1;
      chk($sformatf("st_hold_grant_%0d", n), 32'(grant), 32'd0);
      chk($sformatf("st_hold_busy_%0d", n), 32'(busy), 32'd1);
    end
    chk("st_hold_owner", 32'(owner), 32'd2);
    at_cycle();
    out_ready = 1'b1;
    req = 5'b00001;
    #1;
    chk("st_noreq_grant", 32'(grant), 32'd0);
    chk("st_noreq_busy", 32'(busy), 32'd1);
    at_cycle();
    req = 5'b00101;
    #1;
    chk("st_grant_2", 32'(grant), 32'h04);
    at_cycle();
    #1;
    chk("st_grant_3", 32'(grant), 32'h04);
    at_cycle();
    #1;
    chk("st_release_busy", 32'(busy), 32'd0);
    chk("st_release_grant", 32'(grant), 32'd0);
    at_cycle();
    #1;
    chk("st_l_grant", 32'(grant), 32'h01);
    at_cycle();
    req = 5'b0;
    #1;
    chk("st_l_release", 32'(busy), 32'd0);

    // Early tail: S len 5, TAIL on the 3rd flit.
    at_cycle();
    set_flit(4, HEAD); set_len(4, 5);
    req = 5'b10000;
    #1;
    chk("et_idle_grant", 32'(grant), 32'd0);
    for (int n = 0; n < 3; n++) begin
      at_cycle();
      if (n == 1) set_flit(4, BODY);
      if (n == 2) set_flit(4, TAIL);
      #1;
      chk($sformatf("et_grant_%0d", n), 32'(grant), 32'h10);
    end
    at_cycle();
    req = 5'b0;
    #1;
    chk("et_release_busy", 32'(busy), 32'd0);
    chk("et_release_grant", 32'(grant), 32'd0);

    // Reset mid-packet: N len 3, reset during the 2nd grant.
    at_cycle();
    length = '0;
    for (int i = 0; i < 5; i++) set_flit(i, HEAD);
    set_len(1, 3);
    req = 5'b00010;
    #1;
    chk("rm_idle_grant", 32'(grant), 32'd0);
    at_cycle();
    #1;
    chk("rm_grant_0", 32'(grant), 32'h02);
    at_cycle();
    set_flit(1, BODY);
    rst = 1'b0;
    #1;
    chk("rm_grant_1", 32'(grant), 32'h02);
    at_cycle();
    req = 5'b11111;
    set_flit(1, HEAD);
    length = '0;
    #1;
    chk("rm_after_grant", 32'(grant), 32'd0);
    chk("rm_after_busy", 32'(busy), 32'd0);
    chk("rm_after_owner", 32'(owner), 32'd0);
    rst = 1'b1;
    at_cycle();
    #1;
    chk("rm_first_l", 32'(grant), 32'h01);
    at_cycle();
    req = 5'b0;
    #1;
    chk("rm_release", 32'(busy), 32'd0);

    // Watchdog: E holds the output with out_ready low.
    at_cycle();
    set_len(2, 0);
    req = 5'b00100;
    out_ready = 1'b0;
    #1;
    chk("to_idle_busy", 32'(busy), 32'd0);
    to_cycle = -1;
    to_count = 0;
    busy_after = 1'b1;
    for (int k = 1; k <= 300; k++) begin
      at_cycle();
      #1;
      if (timeout) begin
        to_count++;
        if (to_cycle < 0) to_cycle = k;
      end
`ifdef ARB_TIMEOUT_EN
      if (k == 257) busy_after = busy;
`else
      if (k == 300) busy_after = busy;
`endif
    end
`ifdef ARB_TIMEOUT_EN
    chk("to_pulse_cycle", 32'(to_cycle), 32'd256);
    chk("to_pulse_count", 32'(to_count), 32'd1);
    chk("to_busy_after", 32'(busy_after), 32'd0);
`else
    chk("to_never_pulses", 32'(to_count), 32'd0);
    chk("to_lock_persists", 32'(busy_after), 32'd1);
`endif

    at_cycle();
    rst = 1'b0;
    req = 5'b0;
    out_ready = 1'b1;
    at_cycle();
    #1;
    chk("final_reset_busy", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
